// File: rtl/taus_ctrl_pkg.sv
// Shared types and constants for the Tausworthe URNG sequencer and its step function.
package taus_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WARM  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_S0    = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_S1    = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_S2    = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_START = 2'd3;

  localparam logic [DATA_W-1:0] SEED_MIN0 = 32'd2;
  localparam logic [DATA_W-1:0] SEED_MIN1 = 32'd8;
  localparam logic [DATA_W-1:0] SEED_MIN2 = 32'd16;

  localparam logic [DATA_W-1:0] MASK0 = 32'hFFFF_FFFE;
  localparam logic [DATA_W-1:0] MASK1 = 32'hFFFF_FFF8;
  localparam logic [DATA_W-1:0] MASK2 = 32'hFFFF_FFF0;

  typedef struct packed {
    logic [DATA_W-1:0] s2;
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s0;
  } taus_state_t;

  function automatic logic seeds_valid(taus_state_t s);
    return (s.s0 >= SEED_MIN0) && (s.s1 >= SEED_MIN1) && (s.s2 >= SEED_MIN2);
  endfunction

endpackage

// File: rtl/taus_step.sv
// One combinational step of the three-component Tausworthe generator.
module taus_step
  import taus_ctrl_pkg::*;
(
  input  taus_state_t       st,
  output taus_state_t       st_nxt_c,
  output logic [DATA_W-1:0] out_c
);

  logic [DATA_W-1:0] b0, b1, b2;
  logic [DATA_W-1:0] n0, n1, n2;

  always_comb begin
    b0 = ((st.s0 << 13) ^ st.s0) >> 19;
    n0 = ((st.s0 & MASK0) << 12) ^ b0;
    b1 = ((st.s1 << 2) ^ st.s1) >> 25;
    n1 = ((st.s1 & MASK1) << 4) ^ b1;
    b2 = ((st.s2 << 3) ^ st.s2) >> 11;
    n2 = ((st.s2 & MASK2) << 17) ^ b2;
    st_nxt_c.s0 = n0;
    st_nxt_c.s1 = n1;
    st_nxt_c.s2 = n2;
    out_c       = n0 ^ n1 ^ n2;
  end

endmodule

// File: rtl/taus_ctrl.sv
// Seed load, warm-up and round-robin draw sequencer for the Tausworthe URNG.
// Optional macro TAUS_CTRL_SEED_FIX_EN: force invalid seeds valid instead of flagging seed_err.
module taus_ctrl
  import taus_ctrl_pkg::*;
#(
  parameter int unsigned WARMUP = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  output logic [DATA_W-1:0] rnd_data,
  output logic              rnd_valid,
  output logic              busy,
  output logic              seed_err
);

  state_t            state_q, state_d;
  taus_state_t       sh_q, sh_d;
  taus_state_t       gen_q, gen_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ptr_q, ptr_d;
  logic [1:0]        gnt_d;
  logic [DATA_W-1:0] rnd_data_d;
  logic              rnd_valid_d, busy_d, seed_err_d;

  logic              start_c, win_c;
  taus_state_t       step_nxt_c;
  logic [DATA_W-1:0] step_out_c;

  taus_step u_step (
    .st       (gen_q),
    .st_nxt_c (step_nxt_c),
    .out_c    (step_out_c)
  );

  assign start_c = cfg_we && (cfg_addr == ADDR_START);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    gen_d       = gen_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    gnt_d       = 2'b00;
    rnd_valid_d = 1'b0;
    rnd_data_d  = rnd_data;
    seed_err_d  = seed_err;
    win_c       = 1'b0;

    if (cfg_we) begin
      case (cfg_addr)
        ADDR_S0: sh_d.s0 = cfg_wdata;
        ADDR_S1: sh_d.s1 = cfg_wdata;
        ADDR_S2: sh_d.s2 = cfg_wdata;
        default: ;
      endcase
    end

    // Start aborts whatever is running; no grant is issued on that edge
    if (start_c) begin
      seed_err_d = 1'b0;
      state_d    = ST_CHECK;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_CHECK: begin
`ifdef TAUS_CTRL_SEED_FIX_EN
          gen_d.s0 = sh_q.s0 | SEED_MIN0;
          gen_d.s1 = sh_q.s1 | SEED_MIN1;
          gen_d.s2 = sh_q.s2 | SEED_MIN2;
          cnt_d    = CNT_W'(WARMUP);
          state_d  = ST_WARM;
`else
          if (seeds_valid(sh_q)) begin
            gen_d   = sh_q;
            cnt_d   = CNT_W'(WARMUP);
            state_d = ST_WARM;
          end else begin
            seed_err_d = 1'b1;
            state_d    = ST_IDLE;
          end
`endif
        end
        ST_WARM: begin
          gen_d = step_nxt_c;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (req != 2'b00) begin
            // Contention goes to the side that did not win last
            win_c       = (req == 2'b11) ? ~ptr_q : req[1];
            gen_d       = step_nxt_c;
            gnt_d       = win_c ? 2'b10 : 2'b01;
            rnd_valid_d = 1'b1;
            rnd_data_d  = step_out_c;
            ptr_d       = win_c;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_CHECK) || (state_d == ST_WARM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      gen_q     <= '0;
      cnt_q     <= '0;
      ptr_q     <= 1'b1;
      gnt       <= 2'b00;
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
      busy      <= 1'b0;
      seed_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      gen_q     <= gen_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gnt       <= gnt_d;
      rnd_data  <= rnd_data_d;
      rnd_valid <= rnd_valid_d;
      busy      <= busy_d;
      seed_err  <= seed_err_d;
    end
  end

endmodule

// File: tb/tb_taus_ctrl.sv
// Self-checking bench for taus_ctrl against a behavioural generator/arbiter model.
module tb_taus_ctrl;

  localparam int unsigned WARMUP = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  gnt;
  logic [31:0] rnd_data;
  logic        rnd_valid;
  logic        busy;
  logic        seed_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_s0, m_s1, m_s2;
  logic [31:0] m_sh0 = 0, m_sh1 = 0, m_sh2 = 0;
  int          m_ptr = 1;
  logic        m_err = 1'b0;

  taus_ctrl #(.WARMUP(WARMUP), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .req       (req),
    .gnt       (gnt),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .busy      (busy),
    .seed_err  (seed_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_step(output logic [31:0] o);
    logic [31:0] b;
    b = ((m_s0 << 13) ^ m_s0) >> 19;  m_s0 = ((m_s0 & 32'hFFFFFFFE) << 12) ^ b;
    b = ((m_s1 << 2)  ^ m_s1) >> 25;  m_s1 = ((m_s1 & 32'hFFFFFFF8) << 4)  ^ b;
    b = ((m_s2 << 3)  ^ m_s2) >> 11;  m_s2 = ((m_s2 & 32'hFFFFFFF0) << 17) ^ b;
    o = m_s0 ^ m_s1 ^ m_s2;
  endtask

  // Start command as the model sees it: validate/fix seeds, then discard WARMUP words
  task automatic m_start();
    logic [31:0] junk;
    logic ok;
    ok = (m_sh0 >= 2) && (m_sh1 >= 8) && (m_sh2 >= 16);
`ifdef TAUS_CTRL_SEED_FIX_EN
    ok = 1'b1;
    m_s0 = m_sh0 | 32'd2; m_s1 = m_sh1 | 32'd8; m_s2 = m_sh2 | 32'd16;
`else
    m_s0 = m_sh0; m_s1 = m_sh1; m_s2 = m_sh2;
`endif
    m_err = !ok;
    if (ok) for (int i = 0; i < int'(WARMUP); i++) m_step(junk);
  endtask

  task automatic m_draw(input logic [1:0] r, output logic [1:0] g, output logic [31:0] d);
    int w;
    g = 2'b00;
    d = 32'd0;
    if (r != 2'b00) begin
      if (r == 2'b11) w = (m_ptr == 0) ? 1 : 0;
      else w = r[1] ? 1 : 0;
      m_step(d);
      g = (w == 1) ? 2'b10 : 2'b01;
      m_ptr = w;
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    if (a == 2'd0) m_sh0 = d;
    if (a == 2'd1) m_sh1 = d;
    if (a == 2'd2) m_sh2 = d;
    if (a == 2'd3) m_start();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b00; cfg_we = 1'b0;
    #12;
    n_checks += 5;
    if (gnt !== 2'b00)      begin n_fail++; $display("FAIL reset_gnt got %b want 00", gnt); end
    if (rnd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rnd_valid); end
    if (rnd_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", rnd_data); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    if (seed_err !== 1'b0)  begin n_fail++; $display("FAIL reset_err got %b want 0", seed_err); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_warmup();
    int cnt;
    logic [1:0] g; logic [31:0] d;
    cfg_write(2'd0, 32'd12345); cfg_write(2'd1, 32'd12345); cfg_write(2'd2, 32'd12345);
    cfg_write(2'd3, 32'd0);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      cnt++;
      req = 2'b11;
      n_checks++;
      if (gnt !== 2'b00) begin n_fail++; $display("FAIL warm_gnt cyc %0d got %b want 00", i, gnt); end
      tick();
    end
    n_checks++;
    if (cnt != int'(WARMUP) + 1) begin n_fail++; $display("FAIL warm_busy_len got %0d want %0d", cnt, WARMUP + 1); end
    for (int i = 0; i < 4; i++) begin
      req = 2'b01;
      tick();
      m_draw(2'b01, g, d);
      n_checks += 3;
      if (gnt !== g)          begin n_fail++; $display("FAIL warm_draw_gnt %0d got %b want %b", i, gnt, g); end
      if (rnd_valid !== 1'b1) begin n_fail++; $display("FAIL warm_draw_valid %0d got %b want 1", i, rnd_valid); end
      if (rnd_data !== d)     begin n_fail++; $display("FAIL warm_draw_data %0d got %h want %h", i, rnd_data, d); end
    end
    req = 2'b00;
    tick();
    n_checks++;
    if (gnt !== 2'b00 || rnd_valid !== 1'b0) begin n_fail++; $display("FAIL idle_req gnt %b valid %b want 00/0", gnt, rnd_valid); end
  endtask

  task automatic test_both();
    logic [1:0] g, pg; logic [31:0] d, pd;
    pg = 2'b00; pd = 32'd0;
    for (int i = 0; i < 6; i++) begin
      req = 2'b11;
      tick();
      m_draw(2'b11, g, d);
      n_checks += 3;
      if (gnt !== g)      begin n_fail++; $display("FAIL both_gnt %0d got %b want %b", i, gnt, g); end
      if (rnd_data !== d) begin n_fail++; $display("FAIL both_data %0d got %h want %h", i, rnd_data, d); end
      if (i > 0 && (gnt === pg || rnd_data === pd)) begin
        n_fail++; $display("FAIL both_alternate %0d got %b/%h prev %b/%h want different", i, gnt, rnd_data, pg, pd);
      end
      pg = gnt; pd = rnd_data;
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_random_run();
    logic [1:0] r, g; logic [31:0] d;
    for (int i = 0; i < 40; i++) begin
      r = 2'($urandom_range(0, 3));
      req = r;
      tick();
      m_draw(r, g, d);
      n_checks += 2;
      if (gnt !== g || rnd_valid !== (g != 2'b00)) begin
        n_fail++; $display("FAIL rand_gnt %0d req %b got %b/%b want %b", i, r, gnt, rnd_valid, g);
      end
      if (g != 2'b00 && rnd_data !== d) begin
        n_fail++; $display("FAIL rand_data %0d got %h want %h", i, rnd_data, d);
      end
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_seed_write_restart();
    logic [1:0] g; logic [31:0] d, ns0;
    int cnt;
    ns0 = $urandom() | 32'h100;
    req = 2'b10;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = ns0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cfg_we = 1'b0;
      m_draw(2'b10, g, d);
      n_checks++;
      if (gnt !== g || rnd_data !== d) begin
        n_fail++; $display("FAIL run_write_stream %0d got %b/%h want %b/%h", i, gnt, rnd_data, g, d);
      end
    end
    m_sh0 = ns0;
    cfg_we = 1'b1; cfg_addr = 2'd3; cfg_wdata = $urandom();
    tick();
    cfg_we = 1'b0;
    m_start();
    n_checks += 2;
    if (gnt !== 2'b00) begin n_fail++; $display("FAIL restart_no_grant got %b want 00", gnt); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got %b want 1", busy); end
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      cnt++;
      n_checks++;
      if (gnt !== 2'b00) begin n_fail++; $display("FAIL restart_warm_gnt %0d got %b want 00", i, gnt); end
      tick();
    end
    n_checks++;
    if (cnt != int'(WARMUP) + 1) begin n_fail++; $display("FAIL restart_busy_len got %0d want %0d", cnt, WARMUP + 1); end
    for (int i = 0; i < 3; i++) begin
      tick();
      m_draw(2'b10, g, d);
      n_checks++;
      if (gnt !== g || rnd_data !== d) begin
        n_fail++; $display("FAIL restart_stream %0d got %b/%h want %b/%h", i, gnt, rnd_data, g, d);
      end
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_seed_err();
    logic [1:0] g; logic [31:0] d;
    int cnt;
    cfg_write(2'd0, 32'd1); cfg_write(2'd1, 32'd100); cfg_write(2'd2, 32'd100);
    cfg_write(2'd3, 32'd0);
    tick();
    n_checks += 2;
    if (seed_err !== m_err) begin n_fail++; $display("FAIL seed_err got %b want %b", seed_err, m_err); end
    if (busy !== !m_err)    begin n_fail++; $display("FAIL seed_err_busy got %b want %b", busy, !m_err); end
    if (m_err) begin
      for (int i = 0; i < 5; i++) begin
        req = 2'b11;
        tick();
        n_checks++;
        if (gnt !== 2'b00 || busy !== 1'b0) begin
          n_fail++; $display("FAIL seed_err_idle %0d gnt %b busy %b want 00/0", i, gnt, busy);
        end
      end
    end else begin
      cnt = 0;
      while (busy && cnt < 200) begin tick(); cnt++; end
      req = 2'b01;
      tick();
      m_draw(2'b01, g, d);
      n_checks++;
      if (gnt !== g || rnd_data !== d) begin
        n_fail++; $display("FAIL seed_fix_first got %b/%h want %b/%h", gnt, rnd_data, g, d);
      end
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_warm();
    cfg_write(2'd0, $urandom() | 32'd2);
    cfg_write(2'd1, $urandom() | 32'd8);
    cfg_write(2'd2, $urandom() | 32'd16);
    cfg_write(2'd3, 32'd0);
    repeat (5) tick();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midwarm_busy got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (gnt !== 2'b00 || rnd_valid !== 1'b0 || rnd_data !== 32'd0 || busy !== 1'b0 || seed_err !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got %b/%b/%h/%b/%b want all 0", gnt, rnd_valid, rnd_data, busy, seed_err);
    end
    m_sh0 = 0; m_sh1 = 0; m_sh2 = 0; m_ptr = 1;
    #3 rst_n = 1'b1;
    tick();
    cfg_write(2'd3, 32'd0);
    tick();
    n_checks++;
    if (seed_err !== m_err) begin n_fail++; $display("FAIL zero_seed_err got %b want %b", seed_err, m_err); end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_both();
    test_random_run();
    test_seed_write_restart();
    test_seed_err();
    test_reset_mid_warm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
